// File: rtl/fwd_sel_pipe.sv
// Purpose : ID-stage forwarding/hazard controller; registers per-source EXE operand selects.
// Latency : sel_src_o 1 cycle (registered); hazard_stall_o 0 cycles (combinational).
// Backpress: freeze_i holds every flop; hazard_stall_o stalls PC and IF/ID and bubbles ID/EXE.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   freeze_i                pipeline frozen, all state holds
//   fwd_en_i                1 = forwarding mode, 0 = stall-only mode
//   id_src_i, id_src_vld_i  ID source indices (source s at [s*REG_W +: REG_W]) and read flags
//   exe_wb_en_i, exe_mem_r_i, exe_dest_i   EXE-stage producer (writes / is a load / dest)
//   mem_wb_en_i, mem_dest_i                MEM-stage producer (writes / dest)
//   cnt_clr_i               clear performance counters
//   sel_src_o               per-source select: 00 regfile, 01 MEM ALU result, 10 WB value
//   hazard_stall_o          load-use or no-forward stall
//   stall_cnt_o, fwd_cnt_o  saturating stall-cycle / forwarding-cycle counters
//
// Build option: define FWD_SEL_PERF_CNT_EN to build the performance counters;
// without it both counters read 0 and cnt_clr_i is ignored.

module fwd_sel_pipe #(
    parameter int REG_W   = 4,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       freeze_i,
    input  logic                       fwd_en_i,
    input  logic [NUM_SRC*REG_W-1:0]   id_src_i,
    input  logic [NUM_SRC-1:0]         id_src_vld_i,
    input  logic                       exe_wb_en_i,
    input  logic                       exe_mem_r_i,
    input  logic [REG_W-1:0]           exe_dest_i,
    input  logic                       mem_wb_en_i,
    input  logic [REG_W-1:0]           mem_dest_i,
    input  logic                       cnt_clr_i,
    output logic [2*NUM_SRC-1:0]       sel_src_o,
    output logic                       hazard_stall_o,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           fwd_cnt_o
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    logic [NUM_SRC-1:0]   hit_exe;
    logic [NUM_SRC-1:0]   hit_mem;
    logic [2*NUM_SRC-1:0] sel_d;
    logic [2*NUM_SRC-1:0] sel_q;

    // Per-source comparison against the two in-flight producers. Index 0 is
    // an ordinary register here, so no zero-index exemption.
    always_comb begin
        hit_exe = '0;
        hit_mem = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            hit_exe[s] = id_src_vld_i[s] & exe_wb_en_i
                         & (id_src_i[s*REG_W +: REG_W] == exe_dest_i);
            hit_mem[s] = id_src_vld_i[s] & mem_wb_en_i
                         & (id_src_i[s*REG_W +: REG_W] == mem_dest_i);
        end
    end

    // With forwarding only a load in EXE cannot be bypassed (its data is not
    // ready until the end of MEM); without forwarding any live producer stalls.
    // Deliberately independent of freeze_i.
    always_comb begin
        if (fwd_en_i) begin
            hazard_stall_o = |(hit_exe & {NUM_SRC{exe_mem_r_i}});
        end else begin
            hazard_stall_o = |(hit_exe | hit_mem);
        end
    end

    // Each source picks its own select; the EXE producer is the youngest and
    // wins over MEM. A stalled cycle sends a bubble to EXE, so it reads nothing.
    always_comb begin
        sel_d = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (hazard_stall_o || !fwd_en_i) begin
                sel_d[2*s +: 2] = SEL_RF;
            end else if (hit_exe[s]) begin
                sel_d[2*s +: 2] = SEL_MEM;
            end else if (hit_mem[s]) begin
                sel_d[2*s +: 2] = SEL_WB;
            end else begin
                sel_d[2*s +: 2] = SEL_RF;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sel_q <= '0;
        end else if (!freeze_i) begin
            sel_q <= sel_d;
        end
    end

    assign sel_src_o = sel_q;

`ifdef FWD_SEL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    // Clear beats increment and also acts while frozen; reset beats both.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else if (!freeze_i) begin
            if (hazard_stall_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if ((|sel_q) && (fwd_cnt_q != '1)) begin
                fwd_cnt_q <= fwd_cnt_q + CNT_ONE;
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign fwd_cnt_o   = fwd_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign stall_cnt_o    = '0;
    assign fwd_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_fwd_sel_pipe.sv
// Purpose : scoreboard bench for fwd_sel_pipe (directed sequences + random traffic).
// Latency : checks registered outputs one edge after each stimulus cycle.
// Backpress: none; stimulus issues exactly one record per clock.

module tb_fwd_sel_pipe;

    localparam int RW   = 4;
    localparam int NS   = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 freeze = 1'b0;
    logic                 fwd_en = 1'b1;
    logic [NS*RW-1:0]     id_src = '0;
    logic [NS-1:0]        id_src_vld = '0;
    logic                 exe_wb_en = 1'b0;
    logic                 exe_mem_r = 1'b0;
    logic [RW-1:0]        exe_dest = '0;
    logic                 mem_wb_en = 1'b0;
    logic [RW-1:0]        mem_dest = '0;
    logic                 cnt_clr = 1'b0;
    logic [2*NS-1:0]      sel_src;
    logic                 hazard_stall;
    logic [CW-1:0]        stall_cnt;
    logic [CW-1:0]        fwd_cnt;

    fwd_sel_pipe #(.REG_W(RW), .NUM_SRC(NS), .CNT_W(CW)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .freeze_i       (freeze),
        .fwd_en_i       (fwd_en),
        .id_src_i       (id_src),
        .id_src_vld_i   (id_src_vld),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_r_i    (exe_mem_r),
        .exe_dest_i     (exe_dest),
        .mem_wb_en_i    (mem_wb_en),
        .mem_dest_i     (mem_dest),
        .cnt_clr_i      (cnt_clr),
        .sel_src_o      (sel_src),
        .hazard_stall_o (hazard_stall),
        .stall_cnt_o    (stall_cnt),
        .fwd_cnt_o      (fwd_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            hz;
        logic [2*NS-1:0] sel;
        int              scnt;
        int              fcnt;
        int              id;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_issued = 0;

    // Reference state: what the DUT registers should hold right now.
    int m_sel[NS];
    int m_scnt = 0;
    int m_fcnt = 0;

    // One pipeline cycle: drive inputs shortly after the edge, then predict
    // the combinational stall for these inputs and the state after the next edge.
    task automatic cycle(input bit rst, input bit frz, input bit fen,
                         input logic [NS*RW-1:0] src, input logic [NS-1:0] vld,
                         input bit ew, input bit er, input logic [RW-1:0] ed,
                         input bit mw, input logic [RW-1:0] md, input bit clr);
        exp_t        e;
        bit          stall;
        bit          any_fwd;
        bit          he[NS];
        bit          hm[NS];
        int          nxt[NS];
        logic [RW-1:0] r;
        @(posedge clk);
        #2;
        rst_n = ~rst; freeze = frz; fwd_en = fen; id_src = src; id_src_vld = vld;
        exe_wb_en = ew; exe_mem_r = er; exe_dest = ed;
        mem_wb_en = mw; mem_dest = md; cnt_clr = clr;

        stall = 1'b0;
        for (int s = 0; s < NS; s++) begin
            r     = src[s*RW +: RW];
            he[s] = vld[s] && ew && (r == ed);
            hm[s] = vld[s] && mw && (r == md);
            if (fen) stall = stall || (he[s] && er);
            else     stall = stall || he[s] || hm[s];
        end
        // Youngest matching producer supplies the operand: EXE->from MEM (1), MEM->from WB (2).
        for (int s = 0; s < NS; s++) begin
            if (stall || !fen) nxt[s] = 0;
            else if (he[s])    nxt[s] = 1;
            else if (hm[s])    nxt[s] = 2;
            else               nxt[s] = 0;
        end
        any_fwd = 1'b0;
        for (int s = 0; s < NS; s++) any_fwd = any_fwd || (m_sel[s] != 0);

        if (rst) begin
            for (int s = 0; s < NS; s++) m_sel[s] = 0;
            m_scnt = 0;
            m_fcnt = 0;
        end else begin
            if (!frz) for (int s = 0; s < NS; s++) m_sel[s] = nxt[s];
`ifdef FWD_SEL_PERF_CNT_EN
            if (clr) begin
                m_scnt = 0;
                m_fcnt = 0;
            end else if (!frz) begin
                if (stall && m_scnt < CMAX)   m_scnt = m_scnt + 1;
                if (any_fwd && m_fcnt < CMAX) m_fcnt = m_fcnt + 1;
            end
`endif
        end

        e.hz = stall;
        e.sel = '0;
        for (int s = 0; s < NS; s++) e.sel[2*s +: 2] = 2'(m_sel[s]);
        e.scnt = m_scnt;
        e.fcnt = m_fcnt;
        e.id   = n_issued;
        n_issued++;
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 1, '0, '0, 0, 0, '0, 0, '0, 0);
    endtask

    // Monitor: one edge after a record is issued its inputs are still applied,
    // so hazard_stall reflects them and the registers reflect that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_checks++;
                if (hazard_stall !== e.hz) begin
                    n_errors++;
                    $display("FAIL hazard_stall rec=%0d got=%b exp=%b", e.id, hazard_stall, e.hz);
                end
                n_checks++;
                if (sel_src !== e.sel) begin
                    n_errors++;
                    $display("FAIL sel_src rec=%0d got=%b exp=%b", e.id, sel_src, e.sel);
                end
                n_checks++;
                if (stall_cnt !== CW'(e.scnt)) begin
                    n_errors++;
                    $display("FAIL stall_cnt rec=%0d got=%0d exp=%0d", e.id, stall_cnt, e.scnt);
                end
                n_checks++;
                if (fwd_cnt !== CW'(e.fcnt)) begin
                    n_errors++;
                    $display("FAIL fwd_cnt rec=%0d got=%0d exp=%0d", e.id, fwd_cnt, e.fcnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wait_cyc;
        for (int s = 0; s < NS; s++) m_sel[s] = 0;

        // Reset held 2 cycles under freeze, then idle with no hits.
        cycle(1, 1, 1, '0, '0, 0, 0, '0, 0, '0, 0);
        cycle(1, 1, 1, '0, '0, 0, 0, '0, 0, '0, 0);
        idle(3);

        // Independent sources: src0 hits EXE, src1 hits MEM -> {10,01}.
        cycle(0, 0, 1, {4'd5, 4'd3}, 2'b11, 1, 0, 4'd3, 1, 4'd5, 0);
        idle(2);

        // Priority: both stages write r7 -> EXE wins (01).
        cycle(0, 0, 1, {4'd0, 4'd7}, 2'b01, 1, 0, 4'd7, 1, 4'd7, 0);
        idle(1);

        // Load-use: stall, then the load sits in MEM and forwards from WB.
        cycle(0, 0, 1, {4'd0, 4'd2}, 2'b01, 1, 1, 4'd2, 0, 4'd0, 0);
        cycle(0, 0, 1, {4'd0, 4'd2}, 2'b01, 0, 0, 4'd0, 1, 4'd2, 0);
        idle(2);

        // Stall-only mode: MEM hit stalls, then freeze for 3 cycles.
        cycle(0, 0, 0, {4'd4, 4'd0}, 2'b10, 0, 0, 4'd0, 1, 4'd4, 0);
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, {4'd4, 4'd0}, 2'b10, 0, 0, 4'd0, 1, 4'd4, 0);
        idle(1);

        // Index 0 is not special.
        cycle(0, 0, 1, {4'd0, 4'd0}, 2'b11, 1, 0, 4'd0, 0, 4'd0, 0);
        idle(1);

        // Saturation: 20 stall cycles, then clear.
        for (int i = 0; i < 20; i++)
            cycle(0, 0, 1, {4'd0, 4'd2}, 2'b01, 1, 1, 4'd2, 0, 4'd0, 0);
        cycle(0, 0, 1, '0, '0, 0, 0, '0, 0, '0, 1);
        idle(2);

        // Clear under freeze, and reset in mid-stall.
        cycle(0, 0, 1, {4'd0, 4'd1}, 2'b01, 1, 1, 4'd1, 0, 4'd0, 0);
        cycle(0, 1, 1, {4'd0, 4'd1}, 2'b01, 1, 1, 4'd1, 0, 4'd0, 1);
        cycle(0, 0, 1, {4'd3, 4'd1}, 2'b11, 1, 0, 4'd1, 1, 4'd3, 0);
        cycle(1, 1, 1, {4'd0, 4'd1}, 2'b01, 1, 1, 4'd1, 0, 4'd0, 1);
        idle(1);

        // Random traffic over a small register range to make hits common.
        for (int i = 0; i < 2000; i++) begin
            logic [NS*RW-1:0] src;
            for (int s = 0; s < NS; s++) src[s*RW +: RW] = RW'($urandom_range(0, 3));
            cycle($urandom_range(0, 199) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0,
                  src,
                  NS'($urandom),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0,
                  RW'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1,
                  RW'($urandom_range(0, 3)),
                  $urandom_range(0, 29) == 0);
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #3;
        if (q.size() > 0) begin
            n_errors++;
            $display("FAIL drain got=%0d exp=0 pending records", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fwd_sel_pipe.md
# fwd_sel_pipe

Parametrised, pipelined forwarding and hazard controller for the ARM-style five-stage core. It sits in the ID stage: it compares the decoding instruction's source registers against the destinations of the instructions in EXE and MEM, and registers per-source forwarding selects. Those selects drive the EXE-stage operand muxes one cycle later directly from flops. It also raises a combinational load-use or no-forward stall. Unlike the previous single-stage unit, every source resolves independently with its own priority, a load-use stall is detected, forwarding can be disabled at runtime, and the pipeline freeze is honoured.

## Interface
- REG_W, 4: register index width.
- NUM_SRC, 2: number of source operands, legal 1..4.
- CNT_W, 16: performance counter width.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- freeze  in  1  pipeline frozen (SRAM wait); all registers hold.
- fwd_en  in  1  1 = forwarding mode, 0 = stall-only mode.
- id_src  in  NUM_SRC*REG_W  ID source indices; source s occupies bits [s*REG_W +: REG_W].
- id_src_vld  in  NUM_SRC  per-source "operand is read".
- exe_wb_en  in  1  instruction in EXE writes the register file.
- exe_mem_r  in  1  instruction in EXE is a load.
- exe_dest  in  REG_W  EXE destination index.
- mem_wb_en  in  1  instruction in MEM writes the register file.
- mem_dest  in  REG_W  MEM destination index.
- cnt_clr  in  1  clear performance counters.
- sel_src  out  2*NUM_SRC  registered select per source: 00 = register file, 01 = MEM-stage ALU result, 10 = WB value, 11 never driven.
- hazard_stall  out  1  combinational; holds PC and IF/ID, and bubbles ID/EXE.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- fwd_cnt  out  CNT_W  saturating count of cycles with any nonzero sel_src.

## Operation
- Per valid source s:
  - hit_exe(s) = id_src_vld[s] & exe_wb_en & (id_src[s] == exe_dest).
  - hit_mem(s) = id_src_vld[s] & mem_wb_en & (id_src[s] == mem_dest).
- Stall condition:
  - fwd_en = 1: hazard_stall = OR over s of (hit_exe(s) & exe_mem_r).
  - fwd_en = 0: hazard_stall = OR over s of (hit_exe(s) | hit_mem(s)).
  - hazard_stall is evaluated regardless of freeze.
- Next select for each source, evaluated independently; no source masks another:
  - 00 if hazard_stall = 1 (the bubble entering EXE reads nothing) or fwd_en = 0.
  - Else 01 if hit_exe(s). The EXE producer will be in MEM when this instruction reaches EXE.
  - Else 10 if hit_mem(s). The MEM producer will be in WB.
  - Else 00.
  - EXE takes priority over MEM, so the youngest producer wins.
- A WB-stage match needs no forward: the register file writes through in the same cycle.
- Load-use sequence: stall for one cycle. On the following cycle the load is in MEM, hit_mem gives sel 10, and no further stall occurs.
- Register index 0 is treated like any other index; there is no hardwired-zero exemption.

## Timing
- sel_src is registered. A value computed in cycle N appears in cycle N+1, aligned with the instruction entering EXE.
- hazard_stall has zero-cycle latency and is purely combinational from its inputs.
- freeze = 1 holds sel_src and both counters. Inputs are ignored for state update.
- rst_n = 0 at an edge forces sel_src = 0, stall_cnt = 0 and fwd_cnt = 0. Reset wins over freeze and cnt_clr, and a reset in mid-stall drops everything to zero on the next edge.
- Counters:
  - stall_cnt increments on edges where hazard_stall & !freeze.
  - fwd_cnt increments on edges where sel_src != 0 & !freeze.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr = 1 zeroes both counters on that edge, taking priority over increment, including under freeze.

## Configuration
- FWD_SEL_PERF_CNT_EN defined: stall_cnt, fwd_cnt and cnt_clr behave as described above.
- Macro undefined: no counter flops are built, stall_cnt and fwd_cnt are tied to 0, and cnt_clr is ignored. Forwarding and stall behaviour is identical in both builds.

## Test plan
- Reset: rst_n = 0 for 2 cycles with freeze = 1 and cnt_clr = 0 -> sel_src = 0, stall_cnt = 0, fwd_cnt = 0, and all stay 0 after rst_n = 1 with no hits.
- Independent sources, NUM_SRC = 2: src0 = 3, src1 = 5, exe_dest = 3 (wb_en, non-load), mem_dest = 5 (wb_en) -> next cycle sel_src = {10, 01}; hazard_stall = 0.
- Priority: src0 = 7, exe_dest = 7 and mem_dest = 7, both wb_en -> sel 01.
- Load-use: src0 = 2, exe_dest = 2, exe_mem_r = 1 -> hazard_stall = 1 and next sel 00. On the next cycle, with the load in MEM (mem_dest = 2) -> hazard_stall = 0 and next sel 10. stall_cnt = 1.
- fwd_en = 0: src1 = 4 with mem_dest = 4 -> hazard_stall = 1 and sel 00. With freeze = 1 for 3 cycles, sel and stall_cnt hold.
- Saturation (CNT_W = 4, macro defined): force a stall for 20 cycles -> stall_cnt = 15. Then cnt_clr = 1 -> 0 on the next edge.
